// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake and Memory strobe bundle for mem_access_ctrl.
// The master side is the CPU/Memory environment; the slave side is the controller.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_to_write;
  logic              mem_writeif;
  logic              mem_readif;
  logic              mem_clear;
  logic [DATA_W-1:0] mem_output_data;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_output_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_address, mem_data_to_write, mem_writeif, mem_readif, mem_clear
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_output_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_address, mem_data_to_write, mem_writeif, mem_readif, mem_clear
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding initiator for the single-port Memory: turns read/write/clear
// requests into registered Memory strobes and returns one response per request.
module mem_access_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int READ_LAT  = 1,
  parameter int MEM_DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CLEAR, RESP} state_t;

  localparam logic [1:0]      OP_READ  = 2'b00;
  localparam logic [1:0]      OP_WRITE = 2'b01;
  localparam logic [1:0]      OP_CLEAR = 2'b10;
  localparam logic [1:0]      OP_RSVD  = 2'b11;
  localparam logic [ADDR_W:0] DEPTH    = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [3:0]      LAT_M1   = 4'(READ_LAT - 1);

  state_t            state, state_nxt;
  logic [3:0]        lat_cnt, lat_cnt_nxt;
  logic              ready_nxt, rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt, wdata_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              writeif_nxt, readif_nxt, clear_nxt;

  // Clear ignores the address; every other opcode must target a real word.
  function automatic logic is_reject(input logic [1:0] op, input logic [ADDR_W-1:0] addr);
    return (op == OP_RSVD) || ((op != OP_CLEAR) && ({1'b0, addr} >= DEPTH));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      lat_cnt               <= '0;
      bus.req_ready         <= 1'b1;
      bus.rsp_valid         <= 1'b0;
      bus.rsp_rdata         <= '0;
      bus.rsp_err           <= 1'b0;
      bus.mem_address       <= '0;
      bus.mem_data_to_write <= '0;
      bus.mem_writeif       <= 1'b0;
      bus.mem_readif        <= 1'b0;
      bus.mem_clear         <= 1'b0;
    end else begin
      state                 <= state_nxt;
      lat_cnt               <= lat_cnt_nxt;
      bus.req_ready         <= ready_nxt;
      bus.rsp_valid         <= rsp_valid_nxt;
      bus.rsp_rdata         <= rsp_rdata_nxt;
      bus.rsp_err           <= rsp_err_nxt;
      bus.mem_address       <= addr_nxt;
      bus.mem_data_to_write <= wdata_nxt;
      bus.mem_writeif       <= writeif_nxt;
      bus.mem_readif        <= readif_nxt;
      bus.mem_clear         <= clear_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    lat_cnt_nxt   = lat_cnt;
    ready_nxt     = bus.req_ready;
    rsp_valid_nxt = bus.rsp_valid;
    rsp_rdata_nxt = bus.rsp_rdata;
    rsp_err_nxt   = bus.rsp_err;
    addr_nxt      = bus.mem_address;
    wdata_nxt     = bus.mem_data_to_write;
    writeif_nxt   = 1'b0;
    readif_nxt    = 1'b0;
    clear_nxt     = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          addr_nxt  = bus.req_addr;
          wdata_nxt = bus.req_wdata;
          ready_nxt = 1'b0;
          if (is_reject(bus.req_op, bus.req_addr)) begin
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = '0;
          end else begin
            unique case (bus.req_op)
              OP_WRITE: begin
                state_nxt   = WRITE;
                writeif_nxt = 1'b1;
              end
              OP_CLEAR: begin
                state_nxt = CLEAR;
                clear_nxt = 1'b1;
              end
              default: begin
                state_nxt   = READ;
                readif_nxt  = 1'b1;
                lat_cnt_nxt = LAT_M1;
              end
            endcase
          end
        end
      end
      WRITE, CLEAR: begin
        state_nxt     = RESP;
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = '0;
        rsp_err_nxt   = 1'b0;
      end
      READ: begin
        // readif stays up until the counter has covered READ_LAT cycles
        if (lat_cnt == 4'd0) begin
          state_nxt     = RESP;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = bus.mem_output_data;
          rsp_err_nxt   = 1'b0;
        end else begin
          lat_cnt_nxt = lat_cnt - 4'd1;
          readif_nxt  = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
          ready_nxt     = 1'b1;
        end
      end
      default: begin
        state_nxt     = IDLE;
        rsp_valid_nxt = 1'b0;
        ready_nxt     = 1'b1;
      end
    endcase
  end

  logic unused_op_read;
  assign unused_op_read = ^OP_READ;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: three controllers (READ_LAT 1, 3, 4) share one request stream,
// each paired with a simple word-array Memory model.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_ready;
  int          checks;
  int          errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    mem_access_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    logic [15:0] mem_model [0:1023];

    assign bus.req_valid       = req_valid;
    assign bus.req_op          = req_op;
    assign bus.req_addr        = req_addr;
    assign bus.req_wdata       = req_wdata;
    assign bus.rsp_ready       = rsp_ready;
    assign bus.mem_output_data = bus.mem_readif ? mem_model[bus.mem_address[9:0]] : 16'h0000;

    always @(posedge clk) begin
      if (!rst_n || bus.mem_clear) begin
        for (int i = 0; i < 1024; i++) mem_model[i] <= 16'h0000;
      end else if (bus.mem_writeif) begin
        mem_model[bus.mem_address[9:0]] <= bus.mem_data_to_write;
      end
    end

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .READ_LAT(LAT), .MEM_DEPTH(1024)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    while (!(g_dut[0].bus.req_ready && g_dut[1].bus.req_ready && g_dut[2].bus.req_ready) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL wait_idle: controllers still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata);
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (g_dut[0].bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", g_dut[0].bus.req_ready); end
    checks++; if (g_dut[0].bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", g_dut[0].bus.rsp_valid); end
    checks++; if ({g_dut[0].bus.rsp_err, g_dut[0].bus.rsp_rdata} !== 17'h0) begin errors++; $display("FAIL rst_rsp: err/rdata got %b/%h required 0/0000", g_dut[0].bus.rsp_err, g_dut[0].bus.rsp_rdata); end
    checks++; if ({g_dut[0].bus.mem_address, g_dut[0].bus.mem_data_to_write} !== 32'h0) begin errors++; $display("FAIL rst_mem_bus: addr/data got %h/%h required 0000/0000", g_dut[0].bus.mem_address, g_dut[0].bus.mem_data_to_write); end
    checks++; if ({g_dut[0].bus.mem_writeif, g_dut[0].bus.mem_readif, g_dut[0].bus.mem_clear} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b required 000", {g_dut[0].bus.mem_writeif, g_dut[0].bus.mem_readif, g_dut[0].bus.mem_clear}); end
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    wait_idle();
    issue(2'b01, 16'h0001, 16'h0003);
    checks++; if (g_dut[0].bus.mem_writeif !== 1'b1) begin errors++; $display("FAIL wr_strobe: got %b required 1", g_dut[0].bus.mem_writeif); end
    checks++; if (g_dut[0].bus.mem_address !== 16'h0001 || g_dut[0].bus.mem_data_to_write !== 16'h0003) begin errors++; $display("FAIL wr_bus: addr/data got %h/%h required 0001/0003", g_dut[0].bus.mem_address, g_dut[0].bus.mem_data_to_write); end
    checks++; if (g_dut[0].bus.req_ready !== 1'b0 || g_dut[0].bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_busy: ready/valid got %b/%b required 0/0", g_dut[0].bus.req_ready, g_dut[0].bus.rsp_valid); end
    step();
    checks++; if (g_dut[0].bus.mem_writeif !== 1'b0) begin errors++; $display("FAIL wr_strobe_len: got %b required 0", g_dut[0].bus.mem_writeif); end
    checks++; if ({g_dut[0].bus.rsp_valid, g_dut[0].bus.rsp_err, g_dut[0].bus.rsp_rdata} !== {2'b10, 16'h0000}) begin errors++; $display("FAIL wr_rsp: valid/err/rdata got %b/%b/%h required 1/0/0000", g_dut[0].bus.rsp_valid, g_dut[0].bus.rsp_err, g_dut[0].bus.rsp_rdata); end
    step();
    checks++; if (g_dut[0].bus.rsp_valid !== 1'b0 || g_dut[0].bus.req_ready !== 1'b1) begin errors++; $display("FAIL wr_done: valid/ready got %b/%b required 0/1", g_dut[0].bus.rsp_valid, g_dut[0].bus.req_ready); end
    issue(2'b00, 16'h0001, 16'h0000);
    checks++; if (g_dut[0].bus.mem_readif !== 1'b1 || g_dut[0].bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rd1_strobe: readif/valid got %b/%b required 1/0", g_dut[0].bus.mem_readif, g_dut[0].bus.rsp_valid); end
    step();
    checks++; if (g_dut[0].bus.mem_readif !== 1'b0) begin errors++; $display("FAIL rd1_strobe_len: got %b required 0", g_dut[0].bus.mem_readif); end
    checks++; if ({g_dut[0].bus.rsp_valid, g_dut[0].bus.rsp_err, g_dut[0].bus.rsp_rdata} !== {2'b10, 16'h0003}) begin errors++; $display("FAIL rd1_rsp: valid/err/rdata got %b/%b/%h required 1/0/0003", g_dut[0].bus.rsp_valid, g_dut[0].bus.rsp_err, g_dut[0].bus.rsp_rdata); end
  endtask

  task automatic test_errors();
    wait_idle();
    issue(2'b11, 16'h0005, 16'h0000);
    checks++; if ({g_dut[0].bus.rsp_valid, g_dut[0].bus.rsp_err, g_dut[0].bus.rsp_rdata} !== {2'b11, 16'h0000}) begin errors++; $display("FAIL err_op_rsp: valid/err/rdata got %b/%b/%h required 1/1/0000", g_dut[0].bus.rsp_valid, g_dut[0].bus.rsp_err, g_dut[0].bus.rsp_rdata); end
    checks++; if ({g_dut[0].bus.mem_writeif, g_dut[0].bus.mem_readif, g_dut[0].bus.mem_clear} !== 3'b000) begin errors++; $display("FAIL err_op_strobes: got %b required 000", {g_dut[0].bus.mem_writeif, g_dut[0].bus.mem_readif, g_dut[0].bus.mem_clear}); end
    step();
    checks++; if (g_dut[0].bus.req_ready !== 1'b1 || g_dut[0].bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL err_op_done: ready/valid got %b/%b required 1/0", g_dut[0].bus.req_ready, g_dut[0].bus.rsp_valid); end
    issue(2'b00, 16'd1024, 16'h0000);
    checks++; if ({g_dut[0].bus.rsp_valid, g_dut[0].bus.rsp_err, g_dut[0].bus.rsp_rdata} !== {2'b11, 16'h0000}) begin errors++; $display("FAIL err_addr_rsp: valid/err/rdata got %b/%b/%h required 1/1/0000", g_dut[0].bus.rsp_valid, g_dut[0].bus.rsp_err, g_dut[0].bus.rsp_rdata); end
    checks++; if (g_dut[0].bus.mem_readif !== 1'b0) begin errors++; $display("FAIL err_addr_strobe: readif got %b required 0", g_dut[0].bus.mem_readif); end
    step();
    issue(2'b00, 16'd1023, 16'h0000);
    checks++; if (g_dut[0].bus.mem_readif !== 1'b1 || g_dut[0].bus.mem_address !== 16'h03FF) begin errors++; $display("FAIL last_addr_strobe: readif/addr got %b/%h required 1/03ff", g_dut[0].bus.mem_readif, g_dut[0].bus.mem_address); end
    step();
    checks++; if (g_dut[0].bus.rsp_valid !== 1'b1 || g_dut[0].bus.rsp_err !== 1'b0) begin errors++; $display("FAIL last_addr_rsp: valid/err got %b/%b required 1/0", g_dut[0].bus.rsp_valid, g_dut[0].bus.rsp_err); end
  endtask

  task automatic test_read_latency();
    wait_idle();
    issue(2'b01, 16'h0003, 16'h00A5);
    wait_idle();
    issue(2'b00, 16'h0003, 16'h0000);
    for (int c = 1; c <= 3; c++) begin
      checks++; if (g_dut[1].bus.mem_readif !== 1'b1 || g_dut[1].bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat3_cycle%0d: readif/valid got %b/%b required 1/0", c, g_dut[1].bus.mem_readif, g_dut[1].bus.rsp_valid); end
      step();
    end
    checks++; if (g_dut[1].bus.mem_readif !== 1'b0) begin errors++; $display("FAIL lat3_strobe_len: readif got %b required 0", g_dut[1].bus.mem_readif); end
    checks++; if ({g_dut[1].bus.rsp_valid, g_dut[1].bus.rsp_err, g_dut[1].bus.rsp_rdata} !== {2'b10, 16'h00A5}) begin errors++; $display("FAIL lat3_rsp: valid/err/rdata got %b/%b/%h required 1/0/00a5", g_dut[1].bus.rsp_valid, g_dut[1].bus.rsp_err, g_dut[1].bus.rsp_rdata); end
  endtask

  task automatic test_clear_backpressure();
    wait_idle();
    rsp_ready = 1'b0;
    issue(2'b10, 16'h1234, 16'h0000);
    checks++; if ({g_dut[0].bus.mem_writeif, g_dut[0].bus.mem_readif, g_dut[0].bus.mem_clear} !== 3'b001) begin errors++; $display("FAIL clr_strobe: w/r/c got %b required 001", {g_dut[0].bus.mem_writeif, g_dut[0].bus.mem_readif, g_dut[0].bus.mem_clear}); end
    step();
    checks++; if (g_dut[0].bus.mem_clear !== 1'b0) begin errors++; $display("FAIL clr_strobe_len: got %b required 0", g_dut[0].bus.mem_clear); end
    checks++; if ({g_dut[0].bus.rsp_valid, g_dut[0].bus.rsp_err, g_dut[0].bus.rsp_rdata} !== {2'b10, 16'h0000}) begin errors++; $display("FAIL clr_rsp: valid/err/rdata got %b/%b/%h required 1/0/0000", g_dut[0].bus.rsp_valid, g_dut[0].bus.rsp_err, g_dut[0].bus.rsp_rdata); end
    for (int c = 0; c < 5; c++) begin
      req_op    = 2'b01;
      req_addr  = 16'h0007;
      req_valid = (c == 1);
      step();
      checks++; if ({g_dut[0].bus.rsp_valid, g_dut[0].bus.req_ready, g_dut[0].bus.mem_writeif} !== 3'b100) begin errors++; $display("FAIL clr_stall%0d: valid/ready/writeif got %b/%b/%b required 1/0/0", c, g_dut[0].bus.rsp_valid, g_dut[0].bus.req_ready, g_dut[0].bus.mem_writeif); end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    checks++; if (g_dut[0].bus.rsp_valid !== 1'b0 || g_dut[0].bus.req_ready !== 1'b1) begin errors++; $display("FAIL clr_done: valid/ready got %b/%b required 0/1", g_dut[0].bus.rsp_valid, g_dut[0].bus.req_ready); end
    step();
    checks++; if ({g_dut[0].bus.mem_writeif, g_dut[0].bus.rsp_valid} !== 2'b00) begin errors++; $display("FAIL clr_no_stale: writeif/valid got %b/%b required 0/0", g_dut[0].bus.mem_writeif, g_dut[0].bus.rsp_valid); end
  endtask

  task automatic test_back_to_back();
    wait_idle();
    issue(2'b01, 16'h0005, 16'h0006);
    req_op    = 2'b00;
    req_addr  = 16'h0005;
    req_wdata = 16'h0000;
    req_valid = 1'b1;
    checks++; if (g_dut[0].bus.mem_writeif !== 1'b1 || g_dut[0].bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_c1: writeif/ready got %b/%b required 1/0", g_dut[0].bus.mem_writeif, g_dut[0].bus.req_ready); end
    step();
    checks++; if (g_dut[0].bus.req_ready !== 1'b0 || g_dut[0].bus.mem_readif !== 1'b0) begin errors++; $display("FAIL b2b_c2: ready/readif got %b/%b required 0/0", g_dut[0].bus.req_ready, g_dut[0].bus.mem_readif); end
    step();
    checks++; if (g_dut[0].bus.req_ready !== 1'b1 || g_dut[0].bus.mem_readif !== 1'b0) begin errors++; $display("FAIL b2b_c3: ready/readif got %b/%b required 1/0", g_dut[0].bus.req_ready, g_dut[0].bus.mem_readif); end
    step();
    req_valid = 1'b0;
    checks++; if (g_dut[0].bus.mem_readif !== 1'b1 || g_dut[0].bus.mem_address !== 16'h0005) begin errors++; $display("FAIL b2b_accept: readif/addr got %b/%h required 1/0005", g_dut[0].bus.mem_readif, g_dut[0].bus.mem_address); end
    step();
    checks++; if ({g_dut[0].bus.rsp_valid, g_dut[0].bus.rsp_rdata} !== {1'b1, 16'h0006}) begin errors++; $display("FAIL b2b_rsp: valid/rdata got %b/%h required 1/0006", g_dut[0].bus.rsp_valid, g_dut[0].bus.rsp_rdata); end
  endtask

  task automatic test_reset_mid_read();
    int stale;
    wait_idle();
    issue(2'b00, 16'h0005, 16'h0000);
    checks++; if (g_dut[2].bus.mem_readif !== 1'b1) begin errors++; $display("FAIL mid_rst_c1: readif got %b required 1", g_dut[2].bus.mem_readif); end
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (g_dut[2].bus.mem_readif !== 1'b0 || g_dut[2].bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_async: readif/valid got %b/%b required 0/0", g_dut[2].bus.mem_readif, g_dut[2].bus.rsp_valid); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (g_dut[2].bus.req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b required 1", g_dut[2].bus.req_ready); end
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      if (g_dut[2].bus.rsp_valid !== 1'b0 || g_dut[2].bus.mem_readif !== 1'b0) stale++;
      step();
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL mid_rst_stale: %0d cycles with activity, required 0", stale); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_errors();
    test_read_latency();
    test_clear_backpressure();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
